// File: rtl/snake_pkg.sv
// Shared types and sizes for the snake core: directions, game states and cell widths.
// The grid defaults are shared with the body/bitmap unit.
package snake_pkg;

  localparam int CX_W       = 5;
  localparam int CY_W       = 4;
  localparam int GRID_W_DEF = 20;
  localparam int GRID_H_DEF = 15;

  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
  typedef enum logic [1:0] {IDLE, RUN, STEP, DEAD} state_t;

  function automatic dir_t reverse_dir(input dir_t d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      default: return LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snake_dir_latch.sv
// Direction keypad front end: priority encoder, reversal filter and the pending/current
// direction registers. The pending direction is promoted on load, so one turn per move.
module snake_dir_latch
  import snake_pkg::*;
(
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic sample,
  input  logic load,
  input  logic key_up,
  input  logic key_down,
  input  logic key_left,
  input  logic key_right,
  output dir_t pend_dir
);

  dir_t cur_dir;
  dir_t key_dir;
  dir_t ref_dir;
  logic key_any;

  // During the load cycle the pending direction is what cur_dir is about to become,
  // so the reversal filter compares against that to keep a U-turn from slipping through.
  always_comb begin
    key_any = key_up | key_down | key_left | key_right;
    key_dir = RIGHT;
    if (key_up)
      key_dir = UP;
    else if (key_down)
      key_dir = DOWN;
    else if (key_left)
      key_dir = LEFT;
    ref_dir = load ? pend_dir : cur_dir;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cur_dir  <= RIGHT;
      pend_dir <= RIGHT;
    end else if (clear) begin
      cur_dir  <= RIGHT;
      pend_dir <= RIGHT;
    end else begin
      if (load)
        cur_dir <= pend_dir;
      if (sample && key_any && (key_dir != reverse_dir(ref_dir)))
        pend_dir <= key_dir;
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: game-state FSM, frame-based step cadence, head position arithmetic
// and the per-move step/apple strobes consumed by the body unit.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int GRID_W          = GRID_W_DEF,
  parameter int GRID_H          = GRID_H_DEF,
  parameter int FRAMES_PER_STEP = 8,
  parameter int INIT_X          = 2,
  parameter int INIT_Y          = 7,
  parameter bit WRAP            = 1'b0
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            start_key,
  input  logic            key_up,
  input  logic            key_down,
  input  logic            key_left,
  input  logic            key_right,
  input  logic            startOfFrame,
  input  logic            body_hit,
  input  logic [CX_W-1:0] apple_cx,
  input  logic [CY_W-1:0] apple_cy,
  output logic [CX_W-1:0] head_cx,
  output logic [CY_W-1:0] head_cy,
  output logic            step_tick,
  output logic            apple_eaten,
  output logic            running,
  output logic            gameover,
  output logic [7:0]      score
);

  localparam logic [CX_W-1:0] INIT_CX    = CX_W'(INIT_X);
  localparam logic [CY_W-1:0] INIT_CY    = CY_W'(INIT_Y);
  localparam logic [CX_W-1:0] LAST_CX    = CX_W'(GRID_W - 1);
  localparam logic [CY_W-1:0] LAST_CY    = CY_W'(GRID_H - 1);
  localparam logic [CX_W:0]   GRID_W_X   = (CX_W + 1)'(GRID_W);
  localparam logic [CY_W:0]   GRID_H_Y   = (CY_W + 1)'(GRID_H);
  localparam logic [CX_W:0]   ONE_X      = (CX_W + 1)'(1);
  localparam logic [CY_W:0]   ONE_Y      = (CY_W + 1)'(1);
  localparam logic [7:0]      LAST_FRAME = 8'(FRAMES_PER_STEP - 1);

  state_t          state;
  state_t          state_n;
  dir_t            pend_dir;
  logic            start_q;
  logic            start_rise;
  logic [7:0]      frame_cnt;
  logic            frame_last;
  logic            game_clr;
  logic            do_move;
  logic [CX_W:0]   nx_raw;
  logic [CY_W:0]   ny_raw;
  logic [CX_W-1:0] nx;
  logic [CY_W-1:0] ny;
  logic            off_grid;
  logic            hit_apple;

  assign start_rise = start_key & ~start_q;

  snake_dir_latch u_dir (
    .clk       (clk),
    .resetN    (resetN),
    .clear     (game_clr),
    .sample    ((state == RUN) || (state == STEP)),
    .load      (state == STEP),
    .key_up    (key_up),
    .key_down  (key_down),
    .key_left  (key_left),
    .key_right (key_right),
    .pend_dir  (pend_dir)
  );

  // One extra bit lets -1 (all ones) and GRID_W be told apart from real cells.
  always_comb begin
    nx_raw   = {1'b0, head_cx};
    ny_raw   = {1'b0, head_cy};
    case (pend_dir)
      UP:      ny_raw = ny_raw - ONE_Y;
      DOWN:    ny_raw = ny_raw + ONE_Y;
      LEFT:    nx_raw = nx_raw - ONE_X;
      default: nx_raw = nx_raw + ONE_X;
    endcase
    off_grid = 1'b0;
    nx       = nx_raw[CX_W-1:0];
    ny       = ny_raw[CY_W-1:0];
    if (nx_raw == {(CX_W + 1){1'b1}}) begin
      off_grid = 1'b1;
      nx       = LAST_CX;
    end else if (nx_raw == GRID_W_X) begin
      off_grid = 1'b1;
      nx       = '0;
    end
    if (ny_raw == {(CY_W + 1){1'b1}}) begin
      off_grid = 1'b1;
      ny       = LAST_CY;
    end else if (ny_raw == GRID_H_Y) begin
      off_grid = 1'b1;
      ny       = '0;
    end
    hit_apple = (nx == apple_cx) && (ny == apple_cy);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      state <= IDLE;
    else
      state <= state_n;
  end

  // A body hit in RUN wins over a step trigger arriving in the same cycle.
  always_comb begin
    state_n    = state;
    do_move    = 1'b0;
    frame_last = startOfFrame && (frame_cnt == LAST_FRAME);
    case (state)
      IDLE: if (start_rise) state_n = RUN;
      RUN: begin
        if (body_hit)
          state_n = DEAD;
        else if (frame_last)
          state_n = STEP;
      end
      STEP: begin
        if (off_grid && !WRAP) begin
          state_n = DEAD;
        end else begin
          do_move = 1'b1;
          state_n = RUN;
        end
      end
      DEAD: if (start_rise) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    game_clr = (state_n == IDLE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      start_q   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      start_q <= start_key;
      if (game_clr)
        frame_cnt <= '0;
      else if (((state == RUN) || (state == STEP)) && startOfFrame)
        frame_cnt <= (frame_cnt == LAST_FRAME) ? 8'd0 : frame_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      head_cx     <= INIT_CX;
      head_cy     <= INIT_CY;
      step_tick   <= 1'b0;
      apple_eaten <= 1'b0;
      running     <= 1'b0;
      gameover    <= 1'b0;
      score       <= 8'd0;
    end else begin
      step_tick   <= do_move;
      apple_eaten <= do_move && hit_apple;
      running     <= (state_n == RUN) || (state_n == STEP);
      gameover    <= (state_n == DEAD);
      if (game_clr) begin
        head_cx <= INIT_CX;
        head_cy <= INIT_CY;
        score   <= 8'd0;
      end else if (do_move) begin
        head_cx <= nx;
        head_cy <= ny;
        if (hit_apple && (score != 8'hFF))
          score <= score + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: directed scenarios plus a randomized walk
// compared against a cell/vector model of the game rules.
module tb_snake_game_ctrl;

  localparam int GW  = 20;
  localparam int GH  = 15;
  localparam int FPS = 8;
  localparam logic [3:0] K_UP    = 4'b1000;
  localparam logic [3:0] K_DOWN  = 4'b0100;
  localparam logic [3:0] K_LEFT  = 4'b0010;
  localparam logic [3:0] K_RIGHT = 4'b0001;

  logic       clk = 1'b0;
  logic       resetN0, resetN1;
  logic       start_key, startOfFrame, body_hit;
  logic [3:0] keys;
  logic [4:0] apple_cx;
  logic [3:0] apple_cy;

  logic [4:0] head_cx0, head_cx1;
  logic [3:0] head_cy0, head_cy1;
  logic       step_tick0, step_tick1, apple_eaten0, apple_eaten1;
  logic       running0, running1, gameover0, gameover1;
  logic [7:0] score0, score1;

  int nAssert = 0;
  int nFail   = 0;

  // model: head cell, current and pending move vectors, score, alive flag
  int mHx, mHy, mCdx, mCdy, mPdx, mPdy, mScore;
  bit mAlive;
  bit dual;
  int appleX, appleY;

  always #5 clk = ~clk;

  snake_game_ctrl #(.FRAMES_PER_STEP(FPS), .WRAP(1'b0)) dut0 (
    .clk(clk), .resetN(resetN0), .start_key(start_key),
    .key_up(keys[3]), .key_down(keys[2]), .key_left(keys[1]), .key_right(keys[0]),
    .startOfFrame(startOfFrame), .body_hit(body_hit),
    .apple_cx(apple_cx), .apple_cy(apple_cy),
    .head_cx(head_cx0), .head_cy(head_cy0), .step_tick(step_tick0),
    .apple_eaten(apple_eaten0), .running(running0), .gameover(gameover0), .score(score0)
  );

  snake_game_ctrl #(.FRAMES_PER_STEP(FPS), .WRAP(1'b1)) dut1 (
    .clk(clk), .resetN(resetN1), .start_key(start_key),
    .key_up(keys[3]), .key_down(keys[2]), .key_left(keys[1]), .key_right(keys[0]),
    .startOfFrame(startOfFrame), .body_hit(body_hit),
    .apple_cx(apple_cx), .apple_cy(apple_cy),
    .head_cx(head_cx1), .head_cy(head_cy1), .step_tick(step_tick1),
    .apple_eaten(apple_eaten1), .running(running1), .gameover(gameover1), .score(score1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nAssert++;
    assert (observed === expected)
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] k, input logic sof, input logic bh,
                               input logic sk);
    keys         = k;
    startOfFrame = sof;
    body_hit     = bh;
    start_key    = sk;
    @(posedge clk);
    #1;
  endtask

  task automatic setApple(input int x, input int y);
    appleX   = x;
    appleY   = y;
    apple_cx = x[4:0];
    apple_cy = y[3:0];
  endtask

  task automatic modelStart();
    mHx = 2; mHy = 7;
    mCdx = 1; mCdy = 0;
    mPdx = 1; mPdy = 0;
    mScore = 0;
    mAlive = 1'b1;
  endtask

  task automatic modelKeys(input logic [3:0] k);
    int dx, dy;
    if (k == 4'b0000) return;
    if (k[3])      begin dx = 0;  dy = -1; end
    else if (k[2]) begin dx = 0;  dy = 1;  end
    else if (k[1]) begin dx = -1; dy = 0;  end
    else           begin dx = 1;  dy = 0;  end
    if (!(dx == -mCdx && dy == -mCdy)) begin
      mPdx = dx;
      mPdy = dy;
    end
  endtask

  task automatic pressKeys(input logic [3:0] k, input int n);
    repeat (n) applyStimulus(k, 1'b0, 1'b0, 1'b0);
    modelKeys(k);
  endtask

  task automatic startEdge(input bit expRunning);
    applyStimulus(4'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("startRunning", running0, expRunning);
    checkOutput("startGameover", gameover0, 1'b0);
    applyStimulus(4'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic restartGame();
    startEdge(1'b0);
    checkOutput("idleHeadX", head_cx0, 2);
    checkOutput("idleHeadY", head_cy0, 7);
    checkOutput("idleScore", score0, 0);
    startEdge(1'b1);
    modelStart();
  endtask

  // FPS-1 ordinary frame pulses with random gaps, then the terminal pulse
  task automatic driveFrames(input bit bhTerm);
    int gap;
    for (int f = 0; f < FPS - 1; f++) begin
      applyStimulus(4'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("earlyTick", step_tick0, 1'b0);
      gap = $urandom_range(0, 2);
      repeat (gap) applyStimulus(4'b0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(4'b0, 1'b1, bhTerm, 1'b0);
  endtask

  task automatic runStep();
    int  nx, ny, wx, wy;
    bit  off, eat;
    mCdx = mPdx;
    mCdy = mPdy;
    nx   = mHx + mCdx;
    ny   = mHy + mCdy;
    off  = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
    wx   = (nx + GW) % GW;
    wy   = (ny + GH) % GH;
    eat  = !off && (nx == appleX) && (ny == appleY);
    driveFrames(1'b0);
    checkOutput("stepPhaseTick", step_tick0, 1'b0);
    checkOutput("stepPhaseRunning", running0, 1'b1);
    applyStimulus(4'b0, 1'b0, 1'b0, 1'b0);
    if (off) begin
      checkOutput("wallGameover", gameover0, 1'b1);
      checkOutput("wallNoTick", step_tick0, 1'b0);
      checkOutput("wallRunning", running0, 1'b0);
      checkOutput("wallHeadX", head_cx0, mHx);
      checkOutput("wallHeadY", head_cy0, mHy);
      mAlive = 1'b0;
    end else begin
      mHx = nx;
      mHy = ny;
      if (eat && mScore < 255) mScore++;
      checkOutput("moveTick", step_tick0, 1'b1);
      checkOutput("moveEaten", apple_eaten0, eat);
      checkOutput("moveHeadX", head_cx0, mHx);
      checkOutput("moveHeadY", head_cy0, mHy);
      checkOutput("moveScore", score0, mScore);
      checkOutput("moveGameover", gameover0, 1'b0);
    end
    if (dual) begin
      checkOutput("wrapTick", step_tick1, 1'b1);
      checkOutput("wrapHeadX", head_cx1, wx);
      checkOutput("wrapHeadY", head_cy1, wy);
      checkOutput("wrapGameover", gameover1, 1'b0);
    end
    applyStimulus(4'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("tickOneCycle", step_tick0, 1'b0);
    checkOutput("eatenOneCycle", apple_eaten0, 1'b0);
  endtask

  logic [3:0] sqKeys [4];
  logic [3:0] rk;

  initial begin
    sqKeys  = '{K_RIGHT, K_DOWN, K_LEFT, K_UP};
    dual    = 1'b0;
    resetN0 = 1'b0;
    resetN1 = 1'b0;
    setApple(0, 0);
    applyStimulus(4'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0, 1'b0, 1'b0, 1'b0);

    // reset state
    checkOutput("rstHeadX", head_cx0, 2);
    checkOutput("rstHeadY", head_cy0, 7);
    checkOutput("rstTick", step_tick0, 1'b0);
    checkOutput("rstEaten", apple_eaten0, 1'b0);
    checkOutput("rstRunning", running0, 1'b0);
    checkOutput("rstGameover", gameover0, 1'b0);
    checkOutput("rstScore", score0, 0);
    resetN0 = 1'b1;
    applyStimulus(4'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("idleRunning", running0, 1'b0);

    // start, then first step eats an apple at (3,7)
    startEdge(1'b1);
    modelStart();
    setApple(3, 7);
    runStep();
    setApple(0, 0);

    // reversal ignored, then up wins over down by priority
    pressKeys(K_LEFT, 3);
    runStep();
    pressKeys(K_UP, 2);
    pressKeys(K_UP | K_DOWN, 2);
    runStep();

    // body hit together with the terminal frame pulse
    driveFrames(1'b1);
    checkOutput("bodyGameover", gameover0, 1'b1);
    checkOutput("bodyRunning", running0, 1'b0);
    applyStimulus(4'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("bodyNoTick", step_tick0, 1'b0);
    checkOutput("bodyHeadX", head_cx0, mHx);
    checkOutput("bodyHeadY", head_cy0, mHy);
    restartGame();

    // asynchronous reset while in STEP
    setApple(3, 7);
    runStep();
    setApple(0, 0);
    driveFrames(1'b0);
    resetN0 = 1'b0;
    #1;
    checkOutput("midRstHeadX", head_cx0, 2);
    checkOutput("midRstHeadY", head_cy0, 7);
    checkOutput("midRstScore", score0, 0);
    checkOutput("midRstRunning", running0, 1'b0);
    applyStimulus(4'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("midRstNoTick", step_tick0, 1'b0);
    resetN0 = 1'b1;
    applyStimulus(4'b0, 1'b0, 1'b0, 1'b0);
    startEdge(1'b1);
    modelStart();

    // right edge: wall kills WRAP=0, WRAP=1 comes round to column 0
    resetN0 = 1'b0;
    applyStimulus(4'b0, 1'b0, 1'b0, 1'b0);
    resetN0 = 1'b1;
    resetN1 = 1'b1;
    applyStimulus(4'b0, 1'b0, 1'b0, 1'b0);
    startEdge(1'b1);
    checkOutput("wrapStartRunning", running1, 1'b1);
    modelStart();
    dual = 1'b1;
    for (int i = 0; i < 18; i++) runStep();
    checkOutput("wallDead", mAlive, 1'b0);
    dual    = 1'b0;
    resetN1 = 1'b0;
    restartGame();

    // saturating score: walk a square with an apple on every next cell
    for (int i = 0; i < 256; i++) begin
      if (i % 3 == 0) pressKeys(sqKeys[(i / 3) % 4], 2);
      setApple(mHx + mPdx, mHy + mPdy);
      runStep();
    end
    checkOutput("scoreSaturated", score0, 255);
    setApple(0, 0);

    // randomized walk against the model
    for (int i = 0; i < 60; i++) begin
      rk = 4'($urandom_range(0, 15));
      pressKeys(rk, $urandom_range(1, 3));
      if (($urandom % 2 == 0) && (mHx + mPdx >= 0) && (mHx + mPdx < GW) &&
          (mHy + mPdy >= 0) && (mHy + mPdy < GH))
        setApple(mHx + mPdx, mHy + mPdy);
      else
        setApple($urandom_range(0, GW - 1), $urandom_range(0, GH - 1));
      runStep();
      if (!mAlive) restartGame();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
